// File: rtl/fpu_cvt_pkg.sv
// Shared types and constants for the FPU int/float conversion sequencer.
package fpu_cvt_pkg;

    localparam int unsigned TAG_W  = 5;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        CVT_FTOI = 1'b0,
        CVT_ITOF = 1'b1
    } cvt_op_e;

    typedef struct packed {
        cvt_op_e            op;
        logic [TAG_W-1:0]   tag;
        logic [DATA_W-1:0]  data;
    } cvt_req_t;

    typedef struct packed {
        cvt_op_e            op;
        logic [TAG_W-1:0]   tag;
        logic [DATA_W-1:0]  data;
    } cvt_res_t;

    // One slot of the latency pipe; the operand itself lives in the converters.
    typedef struct packed {
        logic               v;
        cvt_op_e            op;
        logic [TAG_W-1:0]   tag;
    } cvt_pipe_t;

endpackage

// File: rtl/fpu_cvt_fifo.sv
// Result FIFO toward writeback; head entry drives the outputs straight from storage.
module fpu_cvt_fifo
    import fpu_cvt_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  cvt_res_t                     i_data,
    input  logic                         i_pop,
    output logic                         o_valid,
    output cvt_res_t                     o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    cvt_res_t           r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd;
    logic [PTR_W-1:0]   r_wr;
    logic [CNT_W-1:0]   r_count;
    logic               w_pop;
    logic               w_push;

    assign w_pop   = i_pop & (r_count != '0);
    assign w_push  = i_push & ~i_flush;
    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;

    // Pointer and occupancy tracking; push and pop in one cycle leave the count unchanged.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PTR_W'(1);
            if (w_pop)  r_rd <= r_rd + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

endmodule

// File: rtl/fpu_cvt_sequencer.sv
// Issue/collect stage around the ftoi/itof converters with credit-protected result FIFO.
module fpu_cvt_sequencer
    import fpu_cvt_pkg::*;
#(
    parameter int unsigned CVT_LAT    = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [31:0]       req_data,
    output logic [31:0]       cvt_in,
    input  logic [31:0]       ftoi_res,
    input  logic [31:0]       itof_res,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic              wb_op,
    output logic [TAG_W-1:0]  wb_tag,
    output logic [31:0]       wb_data
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = $clog2(FIFO_DEPTH + CVT_LAT + 2) + 1;

    logic                       r_stg_v;
    cvt_req_t                   r_stg;
    cvt_pipe_t [CVT_LAT-1:0]    r_pipe;

    logic                       w_accept;
    logic [SUM_W-1:0]           w_inflight;
    logic [SUM_W-1:0]           w_used;
    logic [CNT_W-1:0]           w_fifo_count;
    logic                       w_tail_v;
    cvt_res_t                   w_tail_res;
    cvt_res_t                   w_head;
    logic                       w_head_v;

    // Credits come only from registered state, so a same-cycle pop frees nothing yet.
    always_comb begin
        w_inflight = SUM_W'(r_stg_v);
        for (int i = 0; i < int'(CVT_LAT); i++) begin
            w_inflight = w_inflight + SUM_W'(r_pipe[i].v);
        end
    end

    assign w_used    = SUM_W'(w_fifo_count) + w_inflight;
    assign req_ready = ~rst & ~flush & (w_used < SUM_W'(FIFO_DEPTH));
    assign w_accept  = req_valid & req_ready;
    assign cvt_in    = r_stg.data;

    // Input stage: valid for one cycle per accept, operand held when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stg_v <= 1'b0;
            r_stg   <= '0;
        end else begin
            r_stg_v <= w_accept & ~flush;
            if (w_accept) begin
                r_stg.op   <= cvt_op_e'(req_op);
                r_stg.tag  <= req_tag;
                r_stg.data <= req_data;
            end
        end
    end

    // Latency pipe marching op/tag alongside the converter datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0].v   <= r_stg_v & ~flush;
            r_pipe[0].op  <= r_stg.op;
            r_pipe[0].tag <= r_stg.tag;
            for (int i = 1; i < int'(CVT_LAT); i++) begin
                r_pipe[i]   <= r_pipe[i-1];
                r_pipe[i].v <= r_pipe[i-1].v & ~flush;
            end
        end
    end

    // Tail selection: credits guarantee room, so the push is unconditional.
    always_comb begin
        w_tail_v        = r_pipe[CVT_LAT-1].v & ~flush;
        w_tail_res.op   = r_pipe[CVT_LAT-1].op;
        w_tail_res.tag  = r_pipe[CVT_LAT-1].tag;
        w_tail_res.data = (r_pipe[CVT_LAT-1].op == CVT_ITOF) ? itof_res : ftoi_res;
    end

    fpu_cvt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (flush),
        .i_push  (w_tail_v),
        .i_data  (w_tail_res),
        .i_pop   (wb_ready),
        .o_valid (w_head_v),
        .o_data  (w_head),
        .o_count (w_fifo_count)
    );

    assign wb_valid = w_head_v;
    assign wb_op    = w_head.op;
    assign wb_tag   = w_head.tag;
    assign wb_data  = w_head.data;

endmodule
